gray_bin_stream: RTL and testbench
==================================

Name: gray_bin_stream

Overview:
- Parametrised, pipelined, streaming Gray/binary converter with a per-beat direction select.
- Both ports use a valid/ready handshake. The output stage is a 2-entry skid buffer, so in_ready is a registered signal.
- Optional Gray-sequence integrity check: flags consecutive Gray inputs that are not Hamming-adjacent, and keeps a saturating error count.
- Sits between Gray-coded position/pointer sources (encoders, async FIFO pointers) and binary-domain consumers; also serves the reverse direction.

Parameters:
- W, 8, data width in bits (≥2).
- CHECK_EN, 1, 1 = enable adjacency check on Gray→binary beats; 0 = err_out tied 0 and err_cnt held at 0.
- ALLOW_REPEAT, 1, 1 = Hamming distance 0 between consecutive Gray inputs is legal; 0 = a repeated value is flagged.
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat; registered.
- in_data  in  W  input code word.
- in_mode  in  1  0 = Gray→binary, 1 = binary→Gray; sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  W  converted word.
- out_mode  out  1  mode of this beat, passed through.
- err_out  out  1  adjacency violation for this beat; 0 for mode-1 beats.
- err_cnt  out  CNT_W  count of flagged beats; saturates at all-ones.

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - out_valid=0, out_data=0, out_mode=0, err_out=0, err_cnt=0.
  - in_ready=1, skid empty, Gray-reference-valid flag cleared.
  - Reset mid-stream drops all held beats; in-flight data is lost without any handshake.
- Accept: an input beat is accepted when in_valid & in_ready at a clk edge. An output beat is transferred when out_valid & out_ready.
- Arithmetic, purely combinational on in_data and registered at accept:
  - mode 0: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0.
  - mode 1: g = b ^ (b>>1).
- Latency: 1 cycle. A beat accepted at edge N is on out_* after edge N when the output register is empty or draining at N.
- Buffering:
  - The output register is the head entry; the skid register is the second entry.
  - If a beat is accepted while the output register is full and not draining, the beat goes to the skid register. in_ready=0 from the next cycle.
  - When the head drains and skid is full, skid moves to head on the same edge and in_ready returns to 1 on the next cycle.
  - Order is always preserved.
  - Full throughput: one beat per cycle when out_ready stays 1.
  - No beat is lost or duplicated under any in_valid/out_ready pattern.
- Adjacency check (CHECK_EN=1, mode-0 beats only):
  - Hamming distance d = popcount(in_data ^ ref), where ref is the last accepted mode-0 input.
  - Flag when d>1, or when d==0 and ALLOW_REPEAT==0.
  - The first mode-0 beat after reset has no ref and is never flagged.
  - ref updates on every accepted mode-0 beat, including flagged ones. Mode-1 beats neither update ref nor get flagged.
  - Wrap from gray(2^W-1) to 0 is distance 1, so it is legal.
- err_out travels with its beat through head and skid.
- err_cnt increments at the accept edge of a flagged beat and stops incrementing once it reaches all-ones.
- Simultaneous push into an empty-draining head with a pop in the same cycle: head is replaced by the new beat, and out_valid stays 1.

Test Plan:
- W=8, out_ready=1, mode 0, in_data=0xC0 -> out_data=0x80 one cycle later, err_out=0.
- Mode 1, in_data=0xFF -> out_data=0x80; in_data=0x80 -> 0xC0; err_out=0, err_cnt unchanged.
- Sweep binary 0..255 in mode 1 back-to-back, then feed the captured results back in mode 0 -> outputs equal 0..255 in order, one per cycle, err_cnt=0 (including the 255→0 wrap).
- Mode 0 sequence 0x00, 0x01, 0x03, 0x00 -> err_out=0,0,0,1; err_cnt=1. With ALLOW_REPEAT=0, 0x03, 0x03 -> second beat flagged, err_cnt=2.
- Backpressure: hold out_ready=0, drive 3 beats 0x01, 0x02, 0x03 (mode 1):
  - in_ready falls after the 2nd accept; 3rd beat is held.
  - Release out_ready -> outputs 0x01, 0x03, 0x02 in order; in_ready recovers.
- Assert rst while skid is full -> next cycle out_valid=0, in_ready=1, err_cnt=0. The next mode-0 beat is not flagged regardless of value.

Source files
------------

// File: rtl/gray_bin_stream.sv
// gray_bin_stream
//   Streaming Gray<->binary converter with a per-beat direction select,
//   a 2-entry output skid buffer (registered in_ready), and an optional
//   Gray-sequence adjacency check with a saturating error counter.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (registered)
//   in_data    input code word [W]
//   in_mode    0 = Gray->binary, 1 = binary->Gray, sampled with the beat
//   out_valid  output beat valid
//   out_ready  downstream accepts
//   out_data   converted word [W]
//   out_mode   mode of this beat
//   err_out    adjacency violation for this beat (always 0 for mode-1 beats)
//   err_cnt    number of flagged beats, saturating [CNT_W]
module gray_bin_stream #(
  parameter int W            = 8,
  parameter int CHECK_EN     = 1,
  parameter int ALLOW_REPEAT = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_mode,
  output logic             err_out,
  output logic [CNT_W-1:0] err_cnt
);

  // Head (output) entry
  logic             head_v_q, head_v_d;
  logic [W-1:0]     head_dat_q, head_dat_d;
  logic             head_m_q, head_m_d;
  logic             head_e_q, head_e_d;
  // Skid (second) entry
  logic             skid_v_q, skid_v_d;
  logic [W-1:0]     skid_dat_q, skid_dat_d;
  logic             skid_m_q, skid_m_d;
  logic             skid_e_q, skid_e_d;
  // Handshake, adjacency reference and error counter
  logic             rdy_q, rdy_d;
  logic [W-1:0]     ref_q, ref_d;
  logic             ref_v_q, ref_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     bin_w, gray_w, conv_w, diff_w;
  logic             multi_w, zero_w, flag_w;
  logic             push, pop;

  // Gray -> binary: prefix XOR from the MSB downwards
  always_comb begin
    bin_w        = '0;
    bin_w[W-1]   = in_data[W-1];
    for (int unsigned k = 1; k < W; k++) begin
      bin_w[W-1-k] = bin_w[W-k] ^ in_data[W-1-k];
    end
  end

  assign gray_w = in_data ^ (in_data >> 1);
  assign conv_w = in_mode ? gray_w : bin_w;

  // Hamming distance classification without a popcount:
  // d==0 iff diff is zero, d>1 iff clearing the lowest set bit leaves bits set.
  assign diff_w  = in_data ^ ref_q;
  assign zero_w  = (diff_w == '0);
  assign multi_w = ((diff_w & (diff_w - W'(1))) != '0);
  assign flag_w  = (CHECK_EN != 0) && !in_mode && ref_v_q &&
                   (multi_w || ((ALLOW_REPEAT == 0) && zero_w));

  assign push = in_valid & rdy_q;
  assign pop  = head_v_q & out_ready;

  always_comb begin
    head_v_d   = head_v_q;
    head_dat_d = head_dat_q;
    head_m_d   = head_m_q;
    head_e_d   = head_e_q;
    skid_v_d   = skid_v_q;
    skid_dat_d = skid_dat_q;
    skid_m_d   = skid_m_q;
    skid_e_d   = skid_e_q;
    ref_d      = ref_q;
    ref_v_d    = ref_v_q;
    cnt_d      = cnt_q;

    // in_ready is low whenever the skid entry is occupied, so a push
    // never coincides with a full skid.
    if (skid_v_q) begin
      if (pop) begin
        head_v_d   = 1'b1;
        head_dat_d = skid_dat_q;
        head_m_d   = skid_m_q;
        head_e_d   = skid_e_q;
        skid_v_d   = 1'b0;
      end
    end else if (!head_v_q || pop) begin
      head_v_d = push;
      if (push) begin
        head_dat_d = conv_w;
        head_m_d   = in_mode;
        head_e_d   = flag_w;
      end
    end else if (push) begin
      skid_v_d   = 1'b1;
      skid_dat_d = conv_w;
      skid_m_d   = in_mode;
      skid_e_d   = flag_w;
    end

    rdy_d = !skid_v_d;

    if (push && !in_mode) begin
      ref_d   = in_data;
      ref_v_d = 1'b1;
    end

    if (push && flag_w && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_v_q   <= 1'b0;
      head_dat_q <= '0;
      head_m_q   <= 1'b0;
      head_e_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      skid_dat_q <= '0;
      skid_m_q   <= 1'b0;
      skid_e_q   <= 1'b0;
      rdy_q      <= 1'b1;
      ref_q      <= '0;
      ref_v_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      head_v_q   <= head_v_d;
      head_dat_q <= head_dat_d;
      head_m_q   <= head_m_d;
      head_e_q   <= head_e_d;
      skid_v_q   <= skid_v_d;
      skid_dat_q <= skid_dat_d;
      skid_m_q   <= skid_m_d;
      skid_e_q   <= skid_e_d;
      rdy_q      <= rdy_d;
      ref_q      <= ref_d;
      ref_v_q    <= ref_v_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = head_v_q;
  assign out_data  = head_dat_q;
  assign out_mode  = head_m_q;
  assign err_out   = head_e_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_gray_bin_stream.sv
// tb_gray_bin_stream
//   Scoreboard bench for gray_bin_stream. Two instances share all inputs:
//   u_dut (ALLOW_REPEAT=1) and u_dut_nr (ALLOW_REPEAT=0). Each accepted
//   beat pushes its expected output into a queue; a monitor pops and
//   compares whenever an output beat transfers.
module tb_gray_bin_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_mode;
  logic        out_ready;

  logic        in_ready, in_ready_b;
  logic        out_valid, out_valid_b;
  logic [7:0]  out_data, out_data_b;
  logic        out_mode, out_mode_b;
  logic        err_out, err_out_b;
  logic [15:0] err_cnt, err_cnt_b;

  typedef struct {
    logic [7:0] d;
    logic       m;
    logic       ea;
    logic       eb;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  gray_bin_stream #(.W(8), .CHECK_EN(1), .ALLOW_REPEAT(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .err_out(err_out), .err_cnt(err_cnt)
  );

  gray_bin_stream #(.W(8), .CHECK_EN(1), .ALLOW_REPEAT(0), .CNT_W(16)) u_dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_mode(out_mode_b),
    .err_out(err_out_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Monitor: a beat transfers at the next edge when out_valid & out_ready
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data",    out_data,    e.d);
        chk("out_mode",    out_mode,    e.m);
        chk("err_out",     err_out,     e.ea);
        chk("out_valid_nr", out_valid_b, 1'b1);
        chk("out_data_nr", out_data_b,  e.d);
        chk("err_out_nr",  err_out_b,   e.eb);
      end
    end
  end

  // Drive one beat; push its expected response at the accepting edge.
  task automatic send(input logic [7:0] d, input logic m, input logic [7:0] xd,
                      input logic xea, input logic xeb);
    int unsigned w = 0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      fail_now("send_timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.d = xd; e.m = m; e.ea = xea; e.eb = xeb;
      q.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain;
    int unsigned w = 0;
    while (q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask

  task automatic chk_cnt(input string nm, input logic [15:0] xa, input logic [15:0] xb);
    chk({nm, "_cnt"},    err_cnt,   xa);
    chk({nm, "_cnt_nr"}, err_cnt_b, xb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    logic [7:0] g;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data,  8'h00);
    chk("rst_out_mode",  out_mode,  1'b0);
    chk("rst_err_out",   err_out,   1'b0);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk_cnt("rst", 16'd0, 16'd0);
    @(posedge clk); #1;

    // Basic conversions and 1-cycle latency
    send(8'hC0, 1'b0, 8'h80, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_data",  out_data,  8'h80);
    @(posedge clk); #1;
    send(8'hFF, 1'b1, 8'h80, 1'b0, 1'b0);
    send(8'h80, 1'b1, 8'hC0, 1'b0, 1'b0);
    wait_drain();
    chk_cnt("basic", 16'd0, 16'd0);

    // Full sweep round trip at one beat per cycle
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 256; i++) begin
      g = 8'(i);
      send(g, 1'b1, g ^ (g >> 1), 1'b0, 1'b0);
    end
    chk("sweep_b2g_cycles", cyc - t0, 256);
    t0 = cyc;
    for (int i = 0; i < 256; i++) begin
      g = 8'(i);
      send(g ^ (g >> 1), 1'b0, g, 1'b0, 1'b0);
    end
    chk("sweep_g2b_cycles", cyc - t0, 256);
    send(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);  // gray(255)=0x80 -> 0x00 wrap
    wait_drain();
    chk_cnt("sweep", 16'd0, 16'd0);

    // Adjacency check
    do_reset();
    send(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
    send(8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    send(8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_drain();
    chk_cnt("adj1", 16'd1, 16'd1);
    send(8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
    send(8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 8'h02, 1'b0, 1'b1);
    wait_drain();
    chk_cnt("adj_rep", 16'd1, 16'd2);
    send(8'h55, 1'b1, 8'h7F, 1'b0, 1'b0);  // mode 1 leaves ref at 0x03
    send(8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    send(8'h0E, 1'b0, 8'h0B, 1'b1, 1'b1);  // flagged beat still becomes ref
    send(8'h0F, 1'b0, 8'h0A, 1'b0, 1'b0);
    wait_drain();
    chk_cnt("adj_ref", 16'd2, 16'd3);

    // Backpressure through the skid entry
    out_ready = 1'b0;
    send(8'h01, 1'b1, 8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b1, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_ready_low", in_ready, 1'b0);
    chk("bp_head",      out_data, 8'h01);
    fork
      send(8'h03, 1'b1, 8'h02, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    @(negedge clk);
    chk("bp_ready_back", in_ready, 1'b1);
    @(posedge clk); #1;

    // Reset with the skid entry full
    out_ready = 1'b0;
    send(8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    send(8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_full_ready", in_ready, 1'b0);
    do_reset();
    @(negedge clk);
    chk("rst2_out_valid",    out_valid,   1'b0);
    chk("rst2_out_valid_nr", out_valid_b, 1'b0);
    chk("rst2_in_ready",     in_ready,    1'b1);
    chk_cnt("rst2", 16'd0, 16'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'hF0, 1'b0, 8'hA0, 1'b0, 1'b0);  // would be distance 5 from old ref
    wait_drain();
    chk_cnt("post_rst", 16'd0, 16'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
